lsu: RTL

Load/store unit forming the memory stage of the pipeline, directly downstream of the execute stage via the ex/mem register. It consumes the ALU op, effective address, store data and write-back fields, runs a single-outstanding data-bus transaction for loads and stores, and stalls the pipeline through `ctrl` until the access completes. Non-memory ops pass through with zero latency to the mem/wb register.

---
 rtl/lsu_bus_if.sv | 15 +
 rtl/lsu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_if.sv
// Data-bus interface between the load/store unit (master) and memory (slave).
// Single outstanding transfer: req/we/addr/sel/wdata are held stable until ack or err.
interface lsu_bus_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (output req, we, addr, sel, wdata, input rdata, ack, err);
  modport slave  (input req, we, addr, sel, wdata, output rdata, ack, err);
endinterface

// File: rtl/lsu.sv
// Load/store unit (memory stage): one outstanding bus access per memory op, stalling until DONE.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses without touching the bus.
module lsu #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o,
  output logic        mem_err_o,
  lsu_bus_if.master   bus
);

  localparam logic [7:0] EXE_LB  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU = 8'b1110_0101;
  localparam logic [7:0] EXE_SB  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW  = 8'b1110_1011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q;

  logic        is_load, is_store, is_mem, is_half, is_word;
  logic        misaligned, start;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c;
  logic [31:0] load_val;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    sel_c    = 4'b0000;
    wdata_c  = reg2_i;
    case (aluop_i)
      EXE_LB, EXE_LBU, EXE_SB: begin
        is_load  = (aluop_i != EXE_SB);
        is_store = (aluop_i == EXE_SB);
        sel_c    = 4'b0001 << mem_addr_i[1:0];
        wdata_c  = {4{reg2_i[7:0]}};
      end
      EXE_LH, EXE_LHU, EXE_SH: begin
        is_load  = (aluop_i != EXE_SH);
        is_store = (aluop_i == EXE_SH);
        is_half  = 1'b1;
        sel_c    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {2{reg2_i[15:0]}};
      end
      EXE_LW, EXE_SW: begin
        is_load  = (aluop_i == EXE_LW);
        is_store = (aluop_i == EXE_SW);
        is_word  = 1'b1;
        sel_c    = 4'b1111;
      end
      default: ;
    endcase
    is_mem = is_load | is_store;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          if (misaligned) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 8'd0;
            err_d   = 1'b0;
            start   = 1'b1;
          end
        end
      end
      BUSY: begin
        // Error takes priority over a coincident ack; timeout only when the slave is silent.
        if (bus.err) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (bus.ack) begin
          state_d = DONE;
          err_d   = 1'b0;
        end else if ((cnt_q + 8'd1) == 8'(BUS_TIMEOUT)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= 32'd0;
      bus.sel   <= 4'd0;
      bus.wdata <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (start) begin
        bus.req   <= 1'b1;
        bus.we    <= is_store;
        bus.addr  <= {mem_addr_i[31:2], 2'b00};
        bus.sel   <= sel_c;
        bus.wdata <= wdata_c;
      end else if (state_d != BUSY) begin
        bus.req <= 1'b0;
      end
      if (state_q == BUSY && bus.ack && !bus.err)
        rdata_q <= bus.rdata;
    end
  end

  always_comb begin
    byte_v = rdata_q[7:0];
    case (mem_addr_i[1:0])
      2'd1:    byte_v = rdata_q[15:8];
      2'd2:    byte_v = rdata_q[23:16];
      2'd3:    byte_v = rdata_q[31:24];
      default: byte_v = rdata_q[7:0];
    endcase
    half_v   = mem_addr_i[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_val = rdata_q;
    case (aluop_i)
      EXE_LB:  load_val = {{24{byte_v[7]}}, byte_v};
      EXE_LBU: load_val = {24'd0, byte_v};
      EXE_LH:  load_val = {{16{half_v[15]}}, half_v};
      EXE_LHU: load_val = {16'd0, half_v};
      default: load_val = rdata_q;
    endcase
  end

  // Memory ops only write back from DONE, and only for a load that completed cleanly.
  always_comb begin
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    stall_req_o = ((state_q == IDLE) && is_mem) || (state_q == BUSY);
    mem_err_o   = (state_q == DONE) && err_q;
    if (is_mem) begin
      wreg_o = 1'b0;
      if (state_q == DONE && is_load && !err_q) begin
        wreg_o  = wreg_i;
        wdata_o = load_val;
      end
    end
    if (rst) begin
      wd_o        = 5'd0;
      wreg_o      = 1'b0;
      wdata_o     = 32'd0;
      stall_req_o = 1'b0;
      mem_err_o   = 1'b0;
    end
  end

endmodule
